dcache: RTL and testbench
=========================

# dcache

Byte-wide data-memory responder for the CHIP-8 core: the target end of the `dmem_*` interface that the CPU drives for loads and stores (FX55/FX65, FX33, DXYN sprite fetch). It holds the 4 KiB CHIP-8 address space in an internal RAM. After reset it fills that RAM with zeros and the built-in hex font. It answers each CPU request with a ready/ack handshake and a configurable wait-state count, and flags illegal accesses.

## Interface
- `ADDR_W`, 12, RAM address width; `MEM_BYTES` = 2**ADDR_W
- `WAIT_CYCLES`, 0, extra busy cycles inserted before each access completes
- `PROTECT`, 1, when 1, writes to 0x000–0x1FF are rejected
- `clk`  in  1  clock, all state changes on rising edge
- `rst_n`  in  1  reset, synchronous, active-low
- `dmem_signal`  in  1  request strobe, sampled only while `dmem_ready`=1
- `dmem_we`  in  1  1 = write, 0 = read; sampled with `dmem_signal`
- `dmem_adr`  in  16  byte address; sampled with `dmem_signal`
- `dmem_wbus`  in  8  write data; sampled with `dmem_signal`
- `dmem_rbus`  out  8  read data, registered; holds last read result
- `dmem_ready`  out  1  responder idle, will accept a request this edge
- `dmem_ack`  out  1  one-cycle completion pulse
- `dmem_err`  out  1  valid only with `dmem_ack`; access rejected

## Operation
- States are INIT, IDLE, BUSY and RESP.
- **Reset:** `rst_n`=0 at any edge does the following:
  - state←INIT, `init_adr`←0, wait counter←0
  - `dmem_rbus`←0x00, `dmem_ready`=0, `dmem_ack`=0, `dmem_err`=0
  - any in-flight request is dropped and never acked.
- **INIT:** each edge with `rst_n`=1:
  - writes `mem[init_adr]`: font byte `FONT[init_adr-FONT_BASE]` if `init_adr` is in FONT_BASE..FONT_BASE+79, else 0x00
  - increments `init_adr`.
  - The edge that writes MEM_BYTES-1 moves to IDLE.
  - `dmem_signal` is ignored throughout INIT.
- **IDLE:** `dmem_ready`=1. An edge with `dmem_signal`=1 latches adr/we/wbus, loads the counter with WAIT_CYCLES and moves to BUSY.
- **BUSY:** `dmem_ready`=0.
  - Counter≠0: decrement.
  - Counter=0: perform the access and move to RESP.
- **Access rules:**
  - `adr[15:ADDR_W]`≠0: out of range. No RAM access, err=1. A read loads `dmem_rbus`←0x00.
  - Write with PROTECT=1 and adr<0x200: RAM unchanged, err=1.
  - Otherwise a read loads `dmem_rbus`←`mem[adr]` and a write sets `mem[adr]`←wbus, with err=0.
  - Writes never alter `dmem_rbus`.
- **RESP:** `dmem_ack`=1 for exactly this cycle, with `dmem_err` per the access rules, `dmem_ready`=0. The next edge moves to IDLE.
- `dmem_signal` asserted in BUSY or RESP is ignored. It is not queued.

## Timing
- Request accepted at edge k. `dmem_ack` is high during the cycle following edge k+WAIT_CYCLES+1.
- `dmem_rbus` is valid in the ack cycle and stays stable until the next read completes.
- Minimum request spacing is WAIT_CYCLES+3 edges (IDLE→BUSY→RESP→IDLE).
- After reset release, `dmem_ready` rises after exactly MEM_BYTES edges (4096 by default).
- Reset on the same edge as an access wins: no RAM write occurs and state goes to INIT.

## Structure
- Package `dmem_pkg` holds:
  - the state enum (INIT/IDLE/BUSY/RESP)
  - `FONT_BASE` = 12'h050, `FONT_BYTES` = 80, `PROT_LIMIT` = 12'h200
  - the 80-byte font constant array (glyphs 0–F, 5 bytes each)
- Sub-module `dmem_ram` is a single-port byte RAM with synchronous write and synchronous read, MEM_BYTES deep.
  - During INIT its port is muxed to the init sweep.
  - Otherwise it is muxed to the latched request.

## Test plan
- **Reset fill:** release `rst_n` and count edges until `dmem_ready`=1; require 4096. Then:
  - read 0x050 → 0xF0
  - read 0x09F → 0x80
  - read 0x0A0 → 0x00
  - err=0 on all three.
- **Write/read:** write 0xA5 to 0x300, then read 0x300.
  - Each access gives exactly one ack, WAIT_CYCLES+1 edges after accept, with err=0.
  - The read returns 0xA5.
  - Repeat with WAIT_CYCLES=0 and WAIT_CYCLES=3.
- **Protection and range:**
  - Write 0x12 to 0x100 → ack with err=1; read 0x100 → 0x00.
  - Read 0x1234 → err=1, rbus 0x00.
  - Write 0x55 to 0xF000 → err=1; read 0x000 → 0x00.
- **Continuous strobe:** hold `dmem_signal`=1 with WAIT_CYCLES=2 and reads to incrementing addresses.
  - Accepts occur every 5 edges.
  - Each ack is a single-cycle pulse.
  - No extra accepts from strobes seen during BUSY or RESP.
- **Reset mid-access:** assert `rst_n`=0 during BUSY of a write of 0x77 to 0x400.
  - No ack is issued.
  - Ready returns after 4096 edges.
  - Read 0x400 → 0x00.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and constants for the CHIP-8 data-memory responder:
// FSM state encoding, memory map limits and the built-in hex font.
package dmem_pkg;

  typedef enum logic [1:0] {
    INIT = 2'd0,
    IDLE = 2'd1,
    BUSY = 2'd2,
    RESP = 2'd3
  } state_t;

  localparam logic [11:0] FONT_BASE  = 12'h050;
  localparam int          FONT_BYTES = 80;
  localparam logic [11:0] PROT_LIMIT = 12'h200;

  // Glyphs 0..F, five rows each, row bits in the upper nibble.
  localparam logic [7:0] FONT [FONT_BYTES] = '{
    8'hF0, 8'h90, 8'h90, 8'h90, 8'hF0,
    8'h20, 8'h60, 8'h20, 8'h20, 8'h70,
    8'hF0, 8'h10, 8'hF0, 8'h80, 8'hF0,
    8'hF0, 8'h10, 8'hF0, 8'h10, 8'hF0,
    8'h90, 8'h90, 8'hF0, 8'h10, 8'h10,
    8'hF0, 8'h80, 8'hF0, 8'h10, 8'hF0,
    8'hF0, 8'h80, 8'hF0, 8'h90, 8'hF0,
    8'hF0, 8'h10, 8'h20, 8'h40, 8'h40,
    8'hF0, 8'h90, 8'hF0, 8'h90, 8'hF0,
    8'hF0, 8'h90, 8'hF0, 8'h10, 8'hF0,
    8'hF0, 8'h90, 8'hF0, 8'h90, 8'h90,
    8'hE0, 8'h90, 8'hE0, 8'h90, 8'hE0,
    8'hF0, 8'h80, 8'h80, 8'h80, 8'hF0,
    8'hE0, 8'h90, 8'h90, 8'h90, 8'hE0,
    8'hF0, 8'h80, 8'hF0, 8'h80, 8'hF0,
    8'hF0, 8'h80, 8'hF0, 8'h80, 8'h80
  };

  // Power-on content of a byte address: font inside the font window, zero elsewhere.
  function automatic logic [7:0] font_byte(input logic [15:0] adr);
    logic [15:0] off;
    off = adr - {4'h0, FONT_BASE};
    if ((adr >= {4'h0, FONT_BASE}) && (off < 16'(FONT_BYTES))) begin
      font_byte = FONT[off[6:0]];
    end else begin
      font_byte = 8'h00;
    end
  endfunction

endpackage

// File: rtl/dmem_ram.sv
// Single-port byte RAM, synchronous write and registered synchronous read.
// The read register can be loaded with zero instead of the array contents.
module dmem_ram #(
  parameter int ADDR_W    = 12,
  parameter int MEM_BYTES = 2 ** ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic              re,
  input  logic              clr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [7:0]        wdata,
  output logic [7:0]        rdata
);

  logic [7:0] mem_r [MEM_BYTES];
  logic [7:0] rdata_r;

  // Array write port; callers gate we with reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[addr] <= wdata;
    end
  end

  // Read register holds its value until the next read.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdata_r <= 8'h00;
    end else if (re) begin
      rdata_r <= clr ? 8'h00 : mem_r[addr];
    end else begin
      rdata_r <= rdata_r;
    end
  end

  assign rdata = rdata_r;

endmodule

// File: rtl/dcache.sv
// CHIP-8 data-memory responder: sweeps font/zero into RAM after reset, then
// serves dmem_* requests with a ready/ack handshake and programmable wait states.
module dcache
  import dmem_pkg::*;
#(
  parameter int ADDR_W      = 12,
  parameter int WAIT_CYCLES = 0,
  parameter bit PROTECT     = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        dmem_signal,
  input  logic        dmem_we,
  input  logic [15:0] dmem_adr,
  input  logic [7:0]  dmem_wbus,
  output logic [7:0]  dmem_rbus,
  output logic        dmem_ready,
  output logic        dmem_ack,
  output logic        dmem_err
);

  localparam int                MEM_BYTES = 2 ** ADDR_W;
  localparam int                CNT_W     = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0]  CNT_LOAD  = CNT_W'(WAIT_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_ZERO  = CNT_W'(0);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [ADDR_W-1:0] INIT_LAST = ADDR_W'(MEM_BYTES - 1);
  localparam logic [ADDR_W-1:0] ADR_ONE   = ADDR_W'(1);

  state_t            state_r;
  state_t            state_s;
  logic [ADDR_W-1:0] init_adr_r;
  logic [CNT_W-1:0]  cnt_r;
  logic [15:0]       adr_r;
  logic              we_r;
  logic [7:0]        wbus_r;
  logic              ready_r;
  logic              ack_r;
  logic              err_r;

  logic              done_s;
  logic              oor_s;
  logic              prot_s;
  logic              rej_s;
  logic              ready_s;
  logic              ack_s;
  logic              err_s;

  logic              ram_we_s;
  logic              ram_re_s;
  logic              ram_clr_s;
  logic [ADDR_W-1:0] ram_addr_s;
  logic [7:0]        ram_wdata_s;
  logic [7:0]        ram_rdata;

  // Classify the latched request; done_s marks the edge the access happens.
  always_comb begin
    done_s = (state_r == BUSY) && (cnt_r == CNT_ZERO);
    oor_s  = (adr_r >> ADDR_W) != 16'h0000;
    prot_s = PROTECT && we_r && (adr_r < {4'h0, PROT_LIMIT});
    rej_s  = oor_s || prot_s;
  end

  // State register together with the registered handshake outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= INIT;
      ready_r <= 1'b0;
      ack_r   <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      state_r <= state_s;
      ready_r <= ready_s;
      ack_r   <= ack_s;
      err_r   <= err_s;
    end
  end

  // Next-state logic; strobes outside IDLE are dropped, not queued.
  always_comb begin
    state_s = state_r;
    case (state_r)
      INIT: begin
        if (init_adr_r == INIT_LAST) state_s = IDLE;
        else                         state_s = INIT;
      end
      IDLE: begin
        if (dmem_signal) state_s = BUSY;
        else             state_s = IDLE;
      end
      BUSY: begin
        if (cnt_r == CNT_ZERO) state_s = RESP;
        else                   state_s = BUSY;
      end
      RESP:    state_s = IDLE;
      default: state_s = INIT;
    endcase
  end

  // Output decode from the next state so the registered outputs line up with it.
  always_comb begin
    ready_s = (state_s == IDLE);
    ack_s   = (state_s == RESP);
    if (done_s) err_s = rej_s;
    else        err_s = 1'b0;
  end

  // Init sweep pointer, wait counter and request latch.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      init_adr_r <= {ADDR_W{1'b0}};
      cnt_r      <= CNT_ZERO;
      adr_r      <= 16'h0000;
      we_r       <= 1'b0;
      wbus_r     <= 8'h00;
    end else begin
      case (state_r)
        INIT: init_adr_r <= init_adr_r + ADR_ONE;
        IDLE: begin
          if (dmem_signal) begin
            adr_r  <= dmem_adr;
            we_r   <= dmem_we;
            wbus_r <= dmem_wbus;
            cnt_r  <= CNT_LOAD;
          end else begin
            cnt_r  <= cnt_r;
          end
        end
        BUSY: begin
          if (cnt_r != CNT_ZERO) cnt_r <= cnt_r - CNT_ONE;
          else                   cnt_r <= cnt_r;
        end
        default: cnt_r <= cnt_r;
      endcase
    end
  end

  // RAM port mux; reset blocks any write on the same edge.
  always_comb begin
    ram_we_s    = 1'b0;
    ram_re_s    = 1'b0;
    ram_clr_s   = 1'b0;
    ram_addr_s  = adr_r[ADDR_W-1:0];
    ram_wdata_s = wbus_r;
    if (state_r == INIT) begin
      ram_addr_s  = init_adr_r;
      ram_wdata_s = font_byte(16'(init_adr_r));
      ram_we_s    = rst_n;
    end else begin
      ram_we_s  = rst_n && done_s && we_r && !rej_s;
      ram_re_s  = rst_n && done_s && !we_r;
      ram_clr_s = oor_s;
    end
  end

  dmem_ram #(
    .ADDR_W    (ADDR_W),
    .MEM_BYTES (MEM_BYTES)
  ) u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (ram_we_s),
    .re    (ram_re_s),
    .clr   (ram_clr_s),
    .addr  (ram_addr_s),
    .wdata (ram_wdata_s),
    .rdata (ram_rdata)
  );

  assign dmem_rbus  = ram_rdata;
  assign dmem_ready = ready_r;
  assign dmem_ack   = ack_r;
  assign dmem_err   = err_r;

endmodule

// File: tb/tb_dcache.sv
// Directed bench for dcache: three instances with 0, 3 and 2 wait states
// share clock and reset; each scenario task checks its own expectations.
module tb_dcache;

  logic        clk;
  logic        rst_n;
  logic        sig   [3];
  logic        we_i  [3];
  logic [15:0] adr   [3];
  logic [7:0]  wbus  [3];
  logic [7:0]  rbus  [3];
  logic        ready [3];
  logic        ack   [3];
  logic        err   [3];

  int checks;
  int passed;

  localparam int WMAX = 3;

  dcache #(.ADDR_W(12), .WAIT_CYCLES(0), .PROTECT(1'b1)) u_w0 (
    .clk(clk), .rst_n(rst_n), .dmem_signal(sig[0]), .dmem_we(we_i[0]),
    .dmem_adr(adr[0]), .dmem_wbus(wbus[0]), .dmem_rbus(rbus[0]),
    .dmem_ready(ready[0]), .dmem_ack(ack[0]), .dmem_err(err[0]));

  dcache #(.ADDR_W(12), .WAIT_CYCLES(3), .PROTECT(1'b1)) u_w3 (
    .clk(clk), .rst_n(rst_n), .dmem_signal(sig[1]), .dmem_we(we_i[1]),
    .dmem_adr(adr[1]), .dmem_wbus(wbus[1]), .dmem_rbus(rbus[1]),
    .dmem_ready(ready[1]), .dmem_ack(ack[1]), .dmem_err(err[1]));

  dcache #(.ADDR_W(12), .WAIT_CYCLES(2), .PROTECT(1'b1)) u_w2 (
    .clk(clk), .rst_n(rst_n), .dmem_signal(sig[2]), .dmem_we(we_i[2]),
    .dmem_adr(adr[2]), .dmem_wbus(wbus[2]), .dmem_rbus(rbus[2]),
    .dmem_ready(ready[2]), .dmem_ack(ack[2]), .dmem_err(err[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Release reset and count edges until each instance raises ready.
  task automatic fill(output int c0, output int c1, output int c2, output int nack);
    int first [3];
    first = '{0, 0, 0};
    nack  = 0;
    rst_n = 1'b1;
    for (int n = 1; n <= 5000; n++) begin
      @(posedge clk); #1;
      for (int i = 0; i < 3; i++) begin
        if (first[i] == 0 && ready[i]) first[i] = n;
        if (ack[i]) nack++;
      end
      if (first[0] != 0 && first[1] != 0 && first[2] != 0) break;
    end
    c0 = first[0];
    c1 = first[1];
    c2 = first[2];
  endtask

  // One request on instance idx; returns data/err at the ack, latency and ack count.
  task automatic access(input int idx, input logic w, input logic [15:0] a, input logic [7:0] d,
                        output logic [7:0] rd, output logic e, output int lat, output int nack);
    int n;
    n = 0;
    while (!ready[idx] && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    sig[idx]  = 1'b1;
    we_i[idx] = w;
    adr[idx]  = a;
    wbus[idx] = d;
    @(posedge clk); #1;
    sig[idx] = 1'b0;
    lat  = -1;
    nack = 0;
    rd   = 8'h00;
    e    = 1'b0;
    for (int i = 1; i <= WMAX + 6; i++) begin
      @(posedge clk); #1;
      if (ack[idx]) begin
        nack++;
        if (lat < 0) begin
          lat = i;
          rd  = rbus[idx];
          e   = err[idx];
        end
      end
    end
  endtask

  task automatic test_reset();
    int c0, c1, c2, nk;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++; if (ready[i] !== 1'b0) $display("FAIL reset_ready[%0d]: got %b want 0", i, ready[i]); else passed++;
      checks++; if (ack[i] !== 1'b0) $display("FAIL reset_ack[%0d]: got %b want 0", i, ack[i]); else passed++;
      checks++; if (err[i] !== 1'b0) $display("FAIL reset_err[%0d]: got %b want 0", i, err[i]); else passed++;
      checks++; if (rbus[i] !== 8'h00) $display("FAIL reset_rbus[%0d]: got %h want 00", i, rbus[i]); else passed++;
    end
    fill(c0, c1, c2, nk);
    checks++; if (c0 !== 4096) $display("FAIL fill_edges_w0: got %0d want 4096", c0); else passed++;
    checks++; if (c1 !== 4096) $display("FAIL fill_edges_w3: got %0d want 4096", c1); else passed++;
    checks++; if (c2 !== 4096) $display("FAIL fill_edges_w2: got %0d want 4096", c2); else passed++;
    checks++; if (nk !== 0) $display("FAIL fill_no_ack: got %0d want 0", nk); else passed++;
  endtask

  task automatic test_font();
    logic [15:0] a  [3] = '{16'h0050, 16'h009F, 16'h00A0};
    logic [7:0]  ex [3] = '{8'hF0, 8'h80, 8'h00};
    logic [7:0]  rd;
    logic        e;
    int          lat, nk;
    for (int i = 0; i < 3; i++) begin
      access(0, 1'b0, a[i], 8'h00, rd, e, lat, nk);
      checks++; if (rd !== ex[i]) $display("FAIL font_data@%h: got %h want %h", a[i], rd, ex[i]); else passed++;
      checks++; if (e !== 1'b0) $display("FAIL font_err@%h: got %b want 0", a[i], e); else passed++;
    end
  endtask

  task automatic test_write_read();
    logic [7:0] rd;
    logic       e;
    int         lat, nk, w;
    for (int idx = 0; idx < 2; idx++) begin
      w = (idx == 0) ? 0 : 3;
      access(idx, 1'b1, 16'h0300, 8'hA5, rd, e, lat, nk);
      checks++; if (lat !== w + 1) $display("FAIL wr_latency W=%0d: got %0d want %0d", w, lat, w + 1); else passed++;
      checks++; if (nk !== 1) $display("FAIL wr_ack_count W=%0d: got %0d want 1", w, nk); else passed++;
      checks++; if (e !== 1'b0) $display("FAIL wr_err W=%0d: got %b want 0", w, e); else passed++;
      access(idx, 1'b0, 16'h0300, 8'h00, rd, e, lat, nk);
      checks++; if (lat !== w + 1) $display("FAIL rd_latency W=%0d: got %0d want %0d", w, lat, w + 1); else passed++;
      checks++; if (nk !== 1) $display("FAIL rd_ack_count W=%0d: got %0d want 1", w, nk); else passed++;
      checks++; if (e !== 1'b0) $display("FAIL rd_err W=%0d: got %b want 0", w, e); else passed++;
      checks++; if (rd !== 8'hA5) $display("FAIL rd_data W=%0d: got %h want a5", w, rd); else passed++;
      // A later write must leave the read register untouched.
      access(idx, 1'b1, 16'h0301, 8'h3C, rd, e, lat, nk);
      checks++; if (rd !== 8'hA5) $display("FAIL wr_keeps_rbus W=%0d: got %h want a5", w, rd); else passed++;
    end
  endtask

  task automatic test_protect_range();
    logic [7:0] rd;
    logic       e;
    int         lat, nk;
    access(0, 1'b1, 16'h0100, 8'h12, rd, e, lat, nk);
    checks++; if (e !== 1'b1) $display("FAIL prot_wr_err: got %b want 1", e); else passed++;
    checks++; if (nk !== 1) $display("FAIL prot_wr_ack: got %0d want 1", nk); else passed++;
    access(0, 1'b0, 16'h0100, 8'h00, rd, e, lat, nk);
    checks++; if (rd !== 8'h00) $display("FAIL prot_rd_data: got %h want 00", rd); else passed++;
    checks++; if (e !== 1'b0) $display("FAIL prot_rd_err: got %b want 0", e); else passed++;
    access(0, 1'b0, 16'h0050, 8'h00, rd, e, lat, nk);
    checks++; if (rd !== 8'hF0) $display("FAIL pre_oor_rd: got %h want f0", rd); else passed++;
    access(0, 1'b0, 16'h1234, 8'h00, rd, e, lat, nk);
    checks++; if (e !== 1'b1) $display("FAIL oor_rd_err: got %b want 1", e); else passed++;
    checks++; if (rd !== 8'h00) $display("FAIL oor_rd_data: got %h want 00", rd); else passed++;
    access(0, 1'b1, 16'hF000, 8'h55, rd, e, lat, nk);
    checks++; if (e !== 1'b1) $display("FAIL oor_wr_err: got %b want 1", e); else passed++;
    access(0, 1'b0, 16'h0000, 8'h00, rd, e, lat, nk);
    checks++; if (rd !== 8'h00) $display("FAIL oor_wr_alias: got %h want 00", rd); else passed++;
    access(0, 1'b1, 16'h0200, 8'h5A, rd, e, lat, nk);
    checks++; if (e !== 1'b0) $display("FAIL prot_edge_wr_err: got %b want 0", e); else passed++;
    access(0, 1'b0, 16'h0200, 8'h00, rd, e, lat, nk);
    checks++; if (rd !== 8'h5A) $display("FAIL prot_edge_rd: got %h want 5a", rd); else passed++;
  endtask

  task automatic test_continuous();
    logic [7:0] ex [4] = '{8'hF0, 8'h10, 8'hF0, 8'h80};
    logic       ea, er;
    int         stray;
    sig[2]  = 1'b1;
    we_i[2] = 1'b0;
    adr[2]  = 16'h005A;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      if (n % 5 == 1) adr[2] = 16'h005A + 16'(n / 5 + 1);
      if (n == 20) sig[2] = 1'b0;
      ea = (n % 5 == 4);
      er = (n % 5 == 0);
      checks++; if (ack[2] !== ea) $display("FAIL cont_ack edge %0d: got %b want %b", n, ack[2], ea); else passed++;
      checks++; if (ready[2] !== er) $display("FAIL cont_ready edge %0d: got %b want %b", n, ready[2], er); else passed++;
      if (ea) begin
        checks++; if (rbus[2] !== ex[n / 5]) $display("FAIL cont_data edge %0d: got %h want %h", n, rbus[2], ex[n / 5]); else passed++;
        checks++; if (err[2] !== 1'b0) $display("FAIL cont_err edge %0d: got %b want 0", n, err[2]); else passed++;
      end
    end
    stray = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (ack[2]) stray++;
    end
    checks++; if (stray !== 0) $display("FAIL cont_stray_ack: got %0d want 0", stray); else passed++;
  endtask

  task automatic test_reset_mid_access();
    logic [7:0] rd;
    logic       e;
    int         lat, nk, c0, c1, c2, racks;
    sig[1] = 1'b1; we_i[1] = 1'b1; adr[1] = 16'h0400; wbus[1] = 8'h77;
    @(posedge clk); #1;
    sig[1] = 1'b0;
    // W=0 instance is accepted one edge later so reset lands on its access edge.
    sig[0] = 1'b1; we_i[0] = 1'b1; adr[0] = 16'h0400; wbus[0] = 8'h77;
    @(posedge clk); #1;
    sig[0] = 1'b0;
    rst_n  = 1'b0;
    racks  = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (ack[0] || ack[1]) racks++;
    end
    checks++; if (racks !== 0) $display("FAIL mid_rst_ack_in_reset: got %0d want 0", racks); else passed++;
    checks++; if (ready[1] !== 1'b0) $display("FAIL mid_rst_ready: got %b want 0", ready[1]); else passed++;
    fill(c0, c1, c2, nk);
    checks++; if (nk !== 0) $display("FAIL mid_rst_ack_after: got %0d want 0", nk); else passed++;
    checks++; if (c1 !== 4096) $display("FAIL mid_rst_fill_w3: got %0d want 4096", c1); else passed++;
    checks++; if (c0 !== 4096) $display("FAIL mid_rst_fill_w0: got %0d want 4096", c0); else passed++;
    access(1, 1'b0, 16'h0400, 8'h00, rd, e, lat, nk);
    checks++; if (rd !== 8'h00) $display("FAIL mid_rst_rd_w3: got %h want 00", rd); else passed++;
    access(0, 1'b0, 16'h0400, 8'h00, rd, e, lat, nk);
    checks++; if (rd !== 8'h00) $display("FAIL mid_rst_rd_w0: got %h want 00", rd); else passed++;
    access(0, 1'b0, 16'h0300, 8'h00, rd, e, lat, nk);
    checks++; if (rd !== 8'h00) $display("FAIL refill_clears_300: got %h want 00", rd); else passed++;
    access(1, 1'b0, 16'h0050, 8'h00, rd, e, lat, nk);
    checks++; if (rd !== 8'hF0) $display("FAIL refill_font: got %h want f0", rd); else passed++;
  endtask

  initial begin
    checks = 0;
    passed = 0;
    rst_n  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sig[i]  = 1'b0;
      we_i[i] = 1'b0;
      adr[i]  = 16'h0000;
      wbus[i] = 8'h00;
    end
    test_reset();
    test_font();
    test_write_read();
    test_protect_range();
    test_continuous();
    test_reset_mid_access();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
